// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b computed LSB first, one bit per clock,
// with a start/busy/done handshake and a registered borrow between bit steps.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 result bits produced so far; the final bit joins them at completion.
  logic [WIDTH-2:0] d_sh;
  logic [WIDTH-1:0] d_nxt;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             ai;
  logic             bi;
  logic             d;
  logic             bo;
  logic             last;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    ai         = a_sh[0];
    bi         = b_sh[0];
    d          = ai ^ bi ^ borrow;
    bo         = (~ai & bi) | (~(ai ^ bi) & borrow);
    d_nxt      = {d, d_sh};
    last       = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      d_sh       <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          d_sh   <= d_nxt[WIDTH-1:1];
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          borrow <= bo;
          if (last) begin
            cnt        <= '0;
            diff       <= d_nxt;
            borrow_out <= bo;
            done       <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, borrow4;
  logic [3:0] diff4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge with the WIDTH=4 unit idle.
  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] exp_d, input logic exp_bo);
    int n;
    int busy_cycles;
    a4 = a; b4 = b; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    busy_cycles = busy4 ? 1 : 0;
    n = 0;
    while (!done4 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (busy4) busy_cycles++;
    end
    check("latency4", n, 4);
    check("busy_cycles4", busy_cycles, 4);
    check("diff4", diff4, exp_d);
    check("borrow4", borrow4, exp_bo);
    @(posedge clk); #1;
    check("done_clear4", done4, 0);
    check("diff_hold4", diff4, exp_d);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int n;
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~a; b8 = ~b;
    n = 0;
    while (!done8 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency8", n, 8);
    check("diff8", diff8, 32'((a - b) & 8'hFF));
    check("borrow8", borrow8, (a < b) ? 1 : 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       bo;
  } vec_t;

  initial begin
    vec_t vecs[6];
    vec_t str[5];
    int   n;
    int   last_done;

    // Reset state
    #12;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_diff", diff4, 0);
    check("rst_borrow", borrow4, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic and edge-value vectors
    vecs[0] = '{4'd9,  4'd3,  4'h6, 1'b0};
    vecs[1] = '{4'd3,  4'd9,  4'hA, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  4'h0, 1'b0};
    vecs[3] = '{4'd15, 4'd15, 4'h0, 1'b0};
    vecs[4] = '{4'd0,  4'd1,  4'hF, 1'b1};
    vecs[5] = '{4'd15, 4'd0,  4'hF, 1'b0};
    foreach (vecs[i]) op4(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo);

    // Idle with start low holds outputs
    repeat (3) @(posedge clk); #1;
    check("idle_busy", busy4, 0);
    check("idle_hold", diff4, 4'hF);

    // start held high: back-to-back results, one per 5 cycles
    str[0] = '{4'd7,  4'd2,  4'h5, 1'b0};
    str[1] = '{4'd2,  4'd7,  4'hB, 1'b1};
    str[2] = '{4'd12, 4'd12, 4'h0, 1'b0};
    str[3] = '{4'd8,  4'd9,  4'hF, 1'b1};
    str[4] = '{4'd14, 4'd5,  4'h9, 1'b0};
    a4 = str[0].a; b4 = str[0].b; start4 = 1'b1;
    @(posedge clk); #1;
    last_done = 0;
    for (int i = 0; i < 5; i++) begin
      a4 = 4'd1; b4 = 4'd13;
      n = 0;
      while (!done4 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("stream_diff", diff4, str[i].d);
      check("stream_borrow", borrow4, str[i].bo);
      if (i > 0) check("stream_period", cyc - last_done, 5);
      last_done = cyc;
      if (i < 4) begin
        a4 = str[i+1].a; b4 = str[i+1].b;
      end else begin
        start4 = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("stream_end_idle", busy4, 1'b0);

    // start mid-SHIFT is ignored
    a4 = 4'd9; b4 = 4'd3; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    a4 = 4'd1; b4 = 4'd14; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ignore_diff", diff4, 4'h6);
    check("ignore_borrow", borrow4, 0);
    @(posedge clk); #1;
    check("ignore_no_requeue", busy4, 0);

    // Asynchronous reset mid-SHIFT aborts the operation
    a4 = 4'd3; b4 = 4'd9; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy4, 0);
    check("abort_diff", diff4, 0);
    check("abort_borrow", borrow4, 0);
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done4) n++;
    end
    check("abort_no_done", n, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    op4(4'd11, 4'd4, 4'h7, 1'b0);

    // WIDTH=8 random sweep
    op8(8'd0, 8'd255);
    op8(8'd255, 8'd0);
    for (int i = 0; i < 1000; i++) op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
